// File: rtl/tt_pkg.sv
// Shared types and constants for the 3-input truth-table sweep reader.
package tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_FINISH
  } tt_state_e;

  localparam int unsigned NUM_COMBOS = 8;

  localparam int unsigned IN1_BIT = 2;
  localparam int unsigned IN2_BIT = 1;
  localparam int unsigned IN3_BIT = 0;

  // Combination 000 lands in the MSB so codes read like the netlist hex names.
  function automatic logic [2:0] tt_bit_pos(input logic [2:0] k);
    return 3'(NUM_COMBOS - 1) - k;
  endfunction

endpackage

// File: rtl/tt_sample_window.sv
// Per-combination sample window: sample counter, last-sample pass-through and
// comparison of every later sample against the first one in the window.
module tt_sample_window #(
  parameter int unsigned SAMPLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  input  logic din,
  output logic last_sample,
  output logic sample_bit,
  output logic differs
);

  logic [7:0] cnt;
  logic       first_q;

  assign last_sample = en && (cnt == 8'(SAMPLE_CYCLES - 1));
  // The recorded value is the one sampled on the closing edge of the window.
  assign sample_bit  = din;
  assign differs     = en && (cnt != '0) && (din != first_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      first_q <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == '0) first_q <= din;
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/tt_sweep_reader.sv
// Sweeps all eight input combinations into a combinational CUT and assembles
// the 8-bit truth-table code, flagging instability inside sample windows.
module tt_sweep_reader
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'h89
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       dut_out,
  output logic [2:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_code,
  output logic       match,
  output logic       unstable
);

  tt_state_e  state;
  logic [7:0] settle_cnt;
  logic [2:0] k;
  logic [7:0] shreg;
  logic       unst;

  logic win_clear, win_en, win_last, win_bit, win_diff;

  assign busy   = (state != ST_IDLE);
  assign dut_in = k;

  assign win_en    = (state == ST_SAMPLE);
  assign win_clear = (state == ST_SETTLE) && !abort &&
                     (settle_cnt == 8'(SETTLE_CYCLES - 1));

  tt_sample_window #(
    .SAMPLE_CYCLES(SAMPLE_CYCLES)
  ) u_window (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (win_clear),
    .en         (win_en),
    .din        (dut_out),
    .last_sample(win_last),
    .sample_bit (win_bit),
    .differs    (win_diff)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      k          <= '0;
      shreg      <= '0;
      unst       <= 1'b0;
      done       <= 1'b0;
      tt_code    <= '0;
      match      <= 1'b0;
      unstable   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            k          <= '0;
            shreg      <= '0;
            unst       <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (abort) begin
            state <= ST_IDLE;
            k     <= '0;
          end else if (win_clear) begin
            state <= ST_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 8'd1;
          end
        end
        ST_SAMPLE: begin
          if (abort) begin
            state <= ST_IDLE;
            k     <= '0;
          end else begin
            unst <= unst | win_diff;
            if (win_last) begin
              shreg <= {shreg[6:0], win_bit};
              if (k == 3'(NUM_COMBOS - 1)) begin
                state <= ST_FINISH;
              end else begin
                k          <= k + 3'd1;
                settle_cnt <= '0;
                state      <= ST_SETTLE;
              end
            end
          end
        end
        ST_FINISH: begin
          tt_code  <= shreg;
          unstable <= unst;
          match    <= (shreg == EXPECTED);
          done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_sweep_reader.sv
// Scoreboard bench for tt_sweep_reader: default-parameter and fast (1/1) instances.
module tb_tt_sweep_reader;
  import tt_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, start2 = 1'b0, abort2 = 1'b0;
  logic [2:0] dut_in, dut_in2;
  logic       dut_out, dut_out2;
  logic       busy, done, match, unstable;
  logic       busy2, done2, match2, unstable2;
  logic [7:0] tt_code, tt_code2;

  typedef struct packed {
    logic [7:0]  code;
    logic        m;
    logic        u;
    logic [31:0] due;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  exp_t        last_exp;
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  int unsigned e0 = 0;
  int          mode = 0;          // 0: NOR netlist model, 1: lookup table
  logic [7:0]  tbl = '0;          // tbl[k] = CUT output for combination k
  logic [7:0]  tbl2 = '0;
  logic        g_on = 1'b0;
  int unsigned g_edge = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic nor89(input logic [2:0] v);
    logic a, b, c;
    a = v[IN1_BIT];
    b = v[IN2_BIT];
    c = v[IN3_BIT];
    return ~((~(a & b) & c) | (b & ~c));
  endfunction

  // Glitch inverts the CUT output during the cycle closed by edge g_edge.
  assign dut_out  = ((mode == 0) ? nor89(dut_in) : tbl[dut_in]) ^ (g_on && (cyc == g_edge - 1));
  assign dut_out2 = tbl2[dut_in2];

  tt_sweep_reader u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_out(dut_out),
    .dut_in(dut_in), .busy(busy), .done(done), .tt_code(tt_code),
    .match(match), .unstable(unstable)
  );

  tt_sweep_reader #(
    .SETTLE_CYCLES(1),
    .SAMPLE_CYCLES(1),
    .EXPECTED     (8'h89)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2), .dut_out(dut_out2),
    .dut_in(dut_in2), .busy(busy2), .done(done2), .tt_code(tt_code2),
    .match(match2), .unstable(unstable2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Reference: per combination, the window sees outs[k] (possibly glitched);
  // the last sample is recorded, any disagreement with the first is unstable.
  function automatic exp_t model(input logic [7:0] outs, input int unsigned s, input int unsigned p,
                                 input logic g, input int unsigned gk, input int unsigned gc);
    exp_t r;
    logic v, v0;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      v0 = 1'b0;
      v  = 1'b0;
      for (int j = 0; j < int'(p); j++) begin
        v = outs[k] ^ (g && (gk == k) && (gc == s + j));
        if (j == 0) v0 = v;
        if (v != v0) r.u = 1'b1;
      end
      r.code = r.code | (8'(v) << (7 - k));
    end
    r.m = (r.code == 8'h89);
    return r;
  endfunction

  task automatic launch(input int sel, input exp_t e, input logic g, input int unsigned gk,
                        input int unsigned gc);
    @(negedge clk);
    e0 = cyc + 1;
    g_on   = g;
    g_edge = e0 + gk * 6 + gc + 1;
    if (sel == 0) begin
      e.due = e0 + 49;
      q1.push_back(e);
      start = 1'b1;
    end else begin
      e.due = e0 + 17;
      q2.push_back(e);
      start2 = 1'b1;
    end
    last_exp = e;
    @(posedge clk);
    #1;
    start  = 1'b0;
    start2 = 1'b0;
    chk("busy_after_start", (sel == 0) ? busy : busy2, 1);
    chk("dut_in_after_start", (sel == 0) ? dut_in : dut_in2, 0);
  endtask

  task automatic drain(input int sel);
    for (int i = 0; i < 300 && ((sel == 0) ? q1.size() : q2.size()) != 0; i++) @(negedge clk);
    chk("drain_timeout", (sel == 0) ? q1.size() : q2.size(), 0);
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int unsigned n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_dut_in"}, dut_in, 0);
    chk({tag, "_tt_code"}, tt_code, 0);
    chk({tag, "_match"}, match, 0);
    chk({tag, "_unstable"}, unstable, 0);
    chk({tag, "_busy2"}, busy2, 0);
    chk({tag, "_tt_code2"}, tt_code2, 0);
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && done) begin
      chk("busy_with_done", busy, 0);
      if (q1.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e = q1.pop_front();
        chk("tt_code", tt_code, e.code);
        chk("match", match, e.m);
        chk("unstable", unstable, e.u);
        chk("done_cycle", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (rst_n && done2) begin
      chk("busy2_with_done2", busy2, 0);
      if (q2.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done2: got done2=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e = q2.pop_front();
        chk("tt_code2", tt_code2, e.code);
        chk("match2", match2, e.m);
        chk("unstable2", unstable2, e.u);
        chk("done2_cycle", cyc, e.due);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic g;
    int unsigned gk, gc;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // NOR netlist for 0x89
    mode = 0;
    e = '{code: 8'h89, m: 1'b1, u: 1'b0, due: 0};
    launch(0, e, 1'b0, 0, 0);
    drain(0);

    // CUT tied high
    mode = 1;
    tbl  = 8'hFF;
    e = '{code: 8'hFF, m: 1'b0, u: 1'b0, due: 0};
    launch(0, e, 1'b0, 0, 0);
    drain(0);

    // Glitch on the first sample of k=3 (cycle offset 4 of 6)
    mode = 0;
    e = '{code: 8'h89, m: 1'b1, u: 1'b1, due: 0};
    launch(0, e, 1'b1, 3, 4);
    drain(0);

    // Random tables with a random single-cycle glitch (may fall in settle)
    mode = 1;
    for (int r = 0; r < 6; r++) begin
      tbl = 8'($urandom);
      g   = 1'($urandom_range(0, 1));
      gk  = $urandom_range(0, 7);
      gc  = $urandom_range(0, 5);
      e   = model(tbl, 4, 2, g, gk, gc);
      launch(0, e, g, gk, gc);
      drain(0);
    end

    // Restart attempt at E0+10, abort sampled at E0+21
    g_on = 1'b0;
    e = last_exp;
    @(negedge clk);
    e0 = cyc + 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_cyc(e0 + 9);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_cyc(e0 + 20);
    chk("busy_before_abort", busy, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("busy_after_abort", busy, 0);
    chk("dut_in_after_abort", dut_in, 0);
    chk("tt_code_kept", tt_code, e.code);
    chk("match_kept", match, e.m);
    chk("unstable_kept", unstable, e.u);
    repeat (60) @(negedge clk);
    chk("busy_idle_after_abort", busy, 0);

    // Asynchronous reset mid-sweep at E0+30
    mode = 0;
    @(negedge clk);
    e0 = cyc + 1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_cyc(e0 + 29);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("busy_after_midreset", busy, 0);
    e = '{code: 8'h89, m: 1'b1, u: 1'b0, due: 0};
    launch(0, e, 1'b0, 0, 0);
    drain(0);

    // Fast instance: CUT tied low, then random tables
    tbl2 = 8'h00;
    e = '{code: 8'h00, m: 1'b0, u: 1'b0, due: 0};
    launch(1, e, 1'b0, 0, 0);
    drain(1);
    for (int r = 0; r < 4; r++) begin
      tbl2 = 8'($urandom);
      e = model(tbl2, 1, 1, 1'b0, 0, 0);
      launch(1, e, 1'b0, 0, 0);
      drain(1);
    end
    tbl2 = 8'b1001_0001;  // outs indexed by k; reads back as 0x89
    e = '{code: 8'h89, m: 1'b1, u: 1'b0, due: 0};
    launch(1, e, 1'b0, 0, 0);
    drain(1);

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
